ysyx_220066_dmem_bridge: RTL and testbench

Data-side memory bridge between the CPU's memory-access stage (MemRd/MemWr/MemOp/addr/data_Wr) and a simple request/grant/response data bus. It converts one CPU load/store into one aligned 64-bit bus beat. It generates byte strobes, realigns and sign/zero-extends load data, and returns data_Rd/data_Rd_valid/data_Rd_error to the write-back stage. It holds the pipeline through busy while a transaction is outstanding.

---
 rtl/ysyx_220066_dmem_pkg.sv | 29 ++
 rtl/ysyx_220066_dmem_align.sv | 64 ++++++
 rtl/ysyx_220066_dmem_bridge.sv | 167 ++++++++++++++++
 tb/tb_ysyx_220066_dmem_bridge.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220066_dmem_pkg.sv
// Shared definitions for the data-memory bridge: access-size codes,
// FSM state encoding and the default bus timeout.
package ysyx_220066_dmem_pkg;

  // RISC-V load/store funct3 codes
  localparam logic [2:0] OP_B    = 3'b000;
  localparam logic [2:0] OP_H    = 3'b001;
  localparam logic [2:0] OP_W    = 3'b010;
  localparam logic [2:0] OP_D    = 3'b011;
  localparam logic [2:0] OP_BU   = 3'b100;
  localparam logic [2:0] OP_HU   = 3'b101;
  localparam logic [2:0] OP_WU   = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int TIMEOUT_DEFAULT = 255;

  // Keeps the address bits at or above the access size (sz = log2 bytes)
  function automatic logic [2:0] lo_keep_mask(input logic [1:0] sz);
    return 3'b111 << sz;
  endfunction

endpackage

// File: rtl/ysyx_220066_dmem_align.sv
// Byte-lane alignment for the data-memory bridge: store strobes and lane
// shift, load extraction with sign/zero extension, misalignment detect.
// Build option YSYX_220066_DMEM_MISALIGN_TRAP_EN: flag misaligned h/w/d
// accesses instead of silently aligning them down.
module ysyx_220066_dmem_align
  import ysyx_220066_dmem_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [2:0]  a,
  input  logic [63:0] wdata,
  input  logic [63:0] bus_rdata,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ext,
  output logic        misalign
);

  logic [2:0]  w_a;
  logic [63:0] w_rd_sh;

`ifdef YSYX_220066_DMEM_MISALIGN_TRAP_EN
  // Offset is used as-is; misaligned h/w/d are reported to the FSM
  always_comb begin
    w_a      = a;
    misalign = ((a & ~lo_keep_mask(mem_op[1:0])) != 3'b000) && (mem_op != OP_RSVD);
  end
`else
  // Offset bits below the access size are dropped: access aligns down
  always_comb begin
    w_a      = a & lo_keep_mask(mem_op[1:0]);
    misalign = 1'b0;
  end
`endif

  // Store strobes and store-data lane placement
  always_comb begin
    wstrb    = 8'h00;
    wdata_sh = wdata << {w_a, 3'b000};
    case (mem_op)
      OP_B, OP_BU: wstrb = 8'h01 << w_a;
      OP_H, OP_HU: wstrb = 8'h03 << w_a;
      OP_W, OP_WU: wstrb = 8'h0F << w_a;
      OP_D:        wstrb = 8'hFF;
      default:     wstrb = 8'h00;
    endcase
  end

  // Load lane extraction with sign or zero extension
  always_comb begin
    w_rd_sh   = bus_rdata >> {w_a, 3'b000};
    rdata_ext = 64'd0;
    case (mem_op)
      OP_B:    rdata_ext = {{56{w_rd_sh[7]}},  w_rd_sh[7:0]};
      OP_H:    rdata_ext = {{48{w_rd_sh[15]}}, w_rd_sh[15:0]};
      OP_W:    rdata_ext = {{32{w_rd_sh[31]}}, w_rd_sh[31:0]};
      OP_D:    rdata_ext = w_rd_sh;
      OP_BU:   rdata_ext = {56'd0, w_rd_sh[7:0]};
      OP_HU:   rdata_ext = {48'd0, w_rd_sh[15:0]};
      OP_WU:   rdata_ext = {32'd0, w_rd_sh[31:0]};
      default: rdata_ext = 64'd0;
    endcase
  end

endmodule

// File: rtl/ysyx_220066_dmem_bridge.sv
// Data-side bridge: turns one CPU load/store into one aligned 64-bit
// request/grant/response bus beat and returns the extended result.
// Build option YSYX_220066_DMEM_MISALIGN_TRAP_EN: misaligned h/w/d
// accesses complete with an error and never reach the bus.
//
// Handshake: a CPU request (mem_rd|mem_wr) is taken in the cycle it is
// seen in IDLE; busy stays high until the DONE cycle. On the bus, bus_req
// holds until a cycle with bus_gnt; the response is the first bus_rvalid
// after the grant (stores use it as write ack). Either wait is bounded by
// TIMEOUT cycles, after which the access completes with rdata_error.
module ysyx_220066_dmem_bridge
  import ysyx_220066_dmem_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              busy,
  output logic [63:0]       rdata,
  output logic              rdata_valid,
  output logic              rdata_error,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [63:0]       bus_wdata,
  output logic [7:0]        bus_wstrb,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [63:0]       bus_rdata,
  input  logic              bus_err,
  output state_t            dbg_state
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  logic [2:0]        r_op;
  logic [2:0]        r_a;
  logic              r_we;
  logic              r_err;
  logic [7:0]        r_cnt;
  logic              r_bus_req;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [63:0]       r_bus_wdata;
  logic [7:0]        r_bus_wstrb;
  logic [63:0]       r_rdata;
  logic              r_valid;
  logic              r_rdata_error;

  logic [2:0]  w_op_sel;
  logic [2:0]  w_a_sel;
  logic [7:0]  w_wstrb;
  logic [63:0] w_wdata_sh;
  logic [63:0] w_rdata_ext;
  logic        w_misalign;
  logic        w_cpu_req;
  logic        w_req_err;

  // Aligner sees the live request in IDLE and the latched access afterwards
  assign w_op_sel  = (r_state == IDLE) ? mem_op    : r_op;
  assign w_a_sel   = (r_state == IDLE) ? addr[2:0] : r_a;
  assign w_cpu_req = mem_rd | mem_wr;
  assign w_req_err = (mem_rd & mem_wr) | (mem_op == OP_RSVD) | w_misalign;

  ysyx_220066_dmem_align u_align (
    .mem_op    (w_op_sel),
    .a         (w_a_sel),
    .wdata     (wdata),
    .bus_rdata (bus_rdata),
    .wstrb     (w_wstrb),
    .wdata_sh  (w_wdata_sh),
    .rdata_ext (w_rdata_ext),
    .misalign  (w_misalign)
  );

  // Transaction FSM with registered bus and result outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_op          <= 3'd0;
      r_a           <= 3'd0;
      r_we          <= 1'b0;
      r_err         <= 1'b0;
      r_cnt         <= 8'd0;
      r_bus_req     <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_wdata   <= 64'd0;
      r_bus_wstrb   <= 8'd0;
      r_rdata       <= 64'd0;
      r_valid       <= 1'b0;
      r_rdata_error <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cpu_req) begin
            r_op        <= mem_op;
            r_a         <= addr[2:0];
            r_we        <= mem_wr;
            r_err       <= w_req_err;
            r_bus_addr  <= {addr[ADDR_W-1:3], 3'b000};
            r_bus_wdata <= w_wdata_sh;
            r_bus_wstrb <= w_wstrb;
            r_bus_req   <= ~w_req_err;
            r_cnt       <= 8'd0;
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (r_err || (!bus_gnt && r_cnt == TO_LAST)) begin
            // rejected request or grant timeout: finish without data
            r_bus_req     <= 1'b0;
            r_rdata       <= 64'd0;
            r_rdata_error <= 1'b1;
            r_valid       <= 1'b1;
            r_state       <= DONE;
          end else if (bus_gnt) begin
            r_bus_req <= 1'b0;
            r_cnt     <= 8'd0;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP: begin
          if (bus_rvalid) begin
            r_rdata       <= r_we ? 64'd0 : w_rdata_ext;
            r_rdata_error <= bus_err;
            r_valid       <= 1'b1;
            r_state       <= DONE;
          end else if (r_cnt == TO_LAST) begin
            r_rdata       <= 64'd0;
            r_rdata_error <= 1'b1;
            r_valid       <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_rdata_error <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = rst & ((r_state == REQ) | (r_state == RESP) |
                              ((r_state == IDLE) & w_cpu_req));
  assign rdata       = r_rdata;
  assign rdata_valid = r_valid;
  assign rdata_error = r_rdata_error;
  assign bus_req     = r_bus_req;
  assign bus_we      = r_we;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign bus_wstrb   = r_bus_wstrb;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ysyx_220066_dmem_bridge.sv
// Bench for the data-memory bridge: directed test-plan transactions plus
// randomized loads/stores, checked every cycle against a transaction-level
// model of timing, strobes, lane placement and load extension.
module tb_ysyx_220066_dmem_bridge;

  localparam int TMO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [2:0]  mem_op = 3'd0;
  logic [63:0] addr = 64'd0, wdata = 64'd0;
  logic        busy, rdata_valid, rdata_error, bus_req, bus_we;
  logic [63:0] rdata, bus_addr, bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
  logic [63:0] bus_rdata = 64'd0;
  logic [1:0]  dbg_state;

  ysyx_220066_dmem_bridge #(.ADDR_W(64), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .busy(busy), .rdata(rdata),
    .rdata_valid(rdata_valid), .rdata_error(rdata_error), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic        chk_en = 1'b0;
  logic        exp_busy = 0, exp_req = 0, exp_valid = 0, exp_err = 0, exp_we = 0;
  logic [63:0] exp_rdata = 0, exp_addr = 0, exp_wdata = 0;
  logic [7:0]  exp_wstrb = 0;
  logic [63:0] last_rdata = 0, last_addr = 0, last_wdata = 0;
  logic [7:0]  last_wstrb = 0;
  logic        last_err = 0, last_we = 0;
  int          req_cycles = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [2:0] eff_a(input logic [2:0] op, input logic [2:0] a);
`ifdef YSYX_220066_DMEM_MISALIGN_TRAP_EN
    return a;
`else
    int n;
    n = 1 << op[1:0];
    return 3'((int'(a) / n) * n);
`endif
  endfunction

  function automatic logic [7:0] model_strb(input logic [2:0] op, input logic [2:0] ae);
    int n;
    if (op[1:0] == 2'd3) return 8'hFF;
    n = 1 << op[1:0];
    return 8'(((1 << n) - 1) << ae);
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] op, input logic [2:0] ae,
                                             input logic [63:0] brd);
    int n;
    logic [63:0] m, v;
    n = 1 << op[1:0];
    m = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
    v = (brd >> (8 * int'(ae))) & m;
    if (!op[2] && n < 8 && v[8 * n - 1]) v = v | ~m;
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {63'd0, busy}, {63'd0, exp_busy});
      chk("bus_req", {63'd0, bus_req}, {63'd0, exp_req});
      chk("rdata_valid", {63'd0, rdata_valid}, {63'd0, exp_valid});
      if (exp_valid) begin
        chk("rdata_error", {63'd0, rdata_error}, {63'd0, exp_err});
        if (!exp_err) begin
          chk("rdata", rdata, exp_q.size() > 0 ? exp_q[0] : exp_rdata);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      if (exp_req) begin
        chk("bus_we", {63'd0, bus_we}, {63'd0, exp_we});
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_wstrb", {56'd0, bus_wstrb}, {56'd0, exp_wstrb});
        chk("bus_wdata", bus_wdata, exp_wdata);
      end
      if (rdata_valid) begin
        last_rdata = rdata;
        last_err   = rdata_error;
      end
      if (bus_req) begin
        req_cycles++;
        last_addr  = bus_addr;
        last_wdata = bus_wdata;
        last_wstrb = bus_wstrb;
        last_we    = bus_we;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      mem_rd = 1'b0; mem_wr = 1'b0;
      mem_op = 3'($urandom_range(0, 7)); addr = {$urandom, $urandom};
      bus_gnt = ($urandom_range(0, 3) == 0);
      bus_rvalid = ($urandom_range(0, 3) == 0);
      bus_rdata = {$urandom, $urandom}; bus_err = 1'($urandom);
      exp_busy = 0; exp_req = 0; exp_valid = 0;
      step();
    end
  endtask

  // One CPU access; g = grant delay after REQ entry, r = rvalid delay after grant
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] wd, input int g,
                         input int r, input logic [63:0] brd, input logic berr);
    logic [2:0] ae;
    logic rerr, to;
    int gc, rc, dc;
    ae   = eff_a(op, a[2:0]);
    rerr = (rd && wr) || (op == 3'b111);
`ifdef YSYX_220066_DMEM_MISALIGN_TRAP_EN
    if (op != 3'b111 && (int'(a[2:0]) % (1 << op[1:0])) != 0) rerr = 1'b1;
`endif
    gc = -1; rc = -1; to = 1'b0;
    if (rerr) dc = 2;
    else if (g >= TMO) begin dc = TMO + 1; to = 1'b1; end
    else begin
      gc = 1 + g;
      if (r >= TMO) begin dc = gc + 1 + TMO; to = 1'b1; end
      else begin rc = gc + 1 + r; dc = rc + 1; end
    end
    exp_we = wr; exp_addr = {a[63:3], 3'b000};
    exp_wstrb = model_strb(op, ae); exp_wdata = wd << (8 * int'(ae));
    exp_err = rerr || to || berr;
    exp_rdata = wr ? 64'd0 : model_load(op, ae, brd);
    if (!exp_err) exp_q.push_back(exp_rdata);
    for (int c = 0; c <= dc; c++) begin
      mem_rd = (c == 0) ? rd : 1'b0;
      mem_wr = (c == 0) ? wr : 1'b0;
      mem_op = (c == 0) ? op : 3'($urandom_range(0, 7));
      addr   = (c == 0) ? a  : {$urandom, $urandom};
      wdata  = (c == 0) ? wd : {$urandom, $urandom};
      bus_gnt = (c == gc) ||
                ((c == 0 || c == dc || (gc >= 0 && c > gc)) && $urandom_range(0, 2) == 0);
      bus_rvalid = (c == rc) || ((c == 0 || c == dc) && $urandom_range(0, 2) == 0);
      bus_rdata  = (c == rc) ? brd  : {$urandom, $urandom};
      bus_err    = (c == rc) ? berr : 1'($urandom);
      exp_busy  = (c < dc);
      exp_req   = !rerr && c >= 1 && c <= ((gc >= 0) ? gc : TMO);
      exp_valid = (c == dc);
      step();
    end
    mem_rd = 1'b0; mem_wr = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    exp_busy = 0; exp_req = 0; exp_valid = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    repeat (3) step();
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_bus_req", {63'd0, bus_req}, 64'd0);
    chk("reset_rdata_valid", {63'd0, rdata_valid}, 64'd0);
    chk("reset_state", {62'd0, dbg_state}, 64'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // lb with sign extension of byte 3
    run_txn(1, 0, 3'b000, 64'h8000_0003, 64'd0, 0, 0, 64'h0000_0000_8000_0000, 0);
    chk("lb_sext_literal", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    idle(1);
    // sh into the top halfword
    run_txn(0, 1, 3'b001, 64'h8000_0006, 64'h1234, 1, 0, 64'd0, 0);
    chk("sh_wstrb_literal", {56'd0, last_wstrb}, 64'hC0);
    chk("sh_wdata_literal", last_wdata, 64'h1234_0000_0000_0000);
    chk("sh_addr_literal", last_addr, 64'h8000_0000);
    chk("sh_we_literal", {63'd0, last_we}, 64'd1);
    // lwu from upper word
    run_txn(1, 0, 3'b110, 64'h8000_0004, 64'd0, 0, 1, 64'hDEAD_BEEF_0000_0000, 0);
    chk("lwu_literal", last_rdata, 64'h0000_0000_DEAD_BEEF);
    // grant never comes
    req_cycles = 0;
    run_txn(1, 0, 3'b011, 64'h8000_0010, 64'd0, 9, 0, 64'd0, 0);
    chk("timeout_req_cycles", 64'(req_cycles), 64'd4);
    chk("timeout_error", {63'd0, last_err}, 64'd1);
    idle(3);
    // bus error, then back-to-back request right after DONE
    run_txn(1, 0, 3'b011, 64'h8000_0018, 64'd0, 0, 0, 64'h55, 1);
    chk("bus_err_error", {63'd0, last_err}, 64'd1);
    run_txn(1, 0, 3'b011, 64'h8000_0020, 64'd0, 0, 0, 64'h0123_4567_89AB_CDEF, 0);
    chk("b2b_rdata", last_rdata, 64'h0123_4567_89AB_CDEF);
    chk("b2b_error", {63'd0, last_err}, 64'd0);
    // misaligned ld
    req_cycles = 0;
    run_txn(1, 0, 3'b011, 64'h8000_0004, 64'd0, 0, 0, 64'hA5A5_0000_1111_2222, 0);
`ifdef YSYX_220066_DMEM_MISALIGN_TRAP_EN
    chk("misalign_no_req", 64'(req_cycles), 64'd0);
    chk("misalign_error", {63'd0, last_err}, 64'd1);
`else
    chk("misalign_addr", last_addr, 64'h8000_0000);
    chk("misalign_wstrb", {56'd0, last_wstrb}, 64'hFF);
    chk("misalign_no_error", {63'd0, last_err}, 64'd0);
`endif
    idle(1);

    // reset while waiting in RESP abandons the access
    chk_en = 1'b0;
    mem_rd = 1'b1; mem_op = 3'b011; addr = 64'h8000_0040;
    step();
    mem_rd = 1'b0; bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("pre_reset_state", {62'd0, dbg_state}, 64'd2);
    rst = 1'b0;
    step();
    bus_rvalid = 1'b1; bus_rdata = 64'hFFFF;
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_bus_req", {63'd0, bus_req}, 64'd0);
    chk("rst_rdata_valid", {63'd0, rdata_valid}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_bus_addr", bus_addr, 64'd0);
    chk("rst_bus_wstrb", {56'd0, bus_wstrb}, 64'd0);
    step();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      bus_rvalid = 1'b0;
      chk("post_rst_no_valid", {63'd0, rdata_valid}, 64'd0);
    end
    exp_busy = 0; exp_req = 0; exp_valid = 0;
    chk_en = 1'b1;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int k, g, r;
      logic rd, wr;
      k  = $urandom_range(0, 19);
      rd = (k < 10) || (k == 19);
      wr = (k >= 10);
      g  = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 2);
      r  = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(0, 2);
      run_txn(rd, wr, 3'($urandom_range(0, 7)), {$urandom, $urandom},
              {$urandom, $urandom}, g, r, {$urandom, $urandom},
              ($urandom_range(0, 7) == 0));
      idle($urandom_range(0, 2));
    end

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
